pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
//  Sequences the system PLL (50 MHz ref -> 27 MHz pixel clk). Drives the PLL reset, qualifies
//  the asynchronous lock flag, and publishes clk_ok: the single "outclk usable" indication for
//  downstream reset bridges. Retries failed lock attempts, counts losses of lock, and accepts
//  restart requests (e.g. after a mode change). Runs on the free-running reference clock.
// PARAMETERS
//  RST_CYCLES     16     PLL reset pulse width, clk cycles (>=2)
//  LOCK_TIMEOUT   50000  max cycles in WAIT_LOCK before a retry (1 ms @ 50 MHz)
//  STABLE_CYCLES  1024   cycles locked must stay continuously high before clk_ok
//  MAX_RETRIES    3      consecutive failed attempts before FAULT (>=1)
//  LOL_W          8      width of the loss-of-lock counter
// PORTS
//  clk          in   1      reference clock (same net that feeds the PLL refclk)
//  reset_n      in   1      asynchronous active-low reset
//  pll_locked   in   1      PLL locked, asynchronous to clk
//  pll_rst      out  1      PLL reset, active high
//  restart_req  in   1      level request to re-sequence the PLL
//  restart_ack  out  1      1-cycle pulse; request accepted
//  clk_ok       out  1      PLL output is stable; downstream may release its resets
//  fault        out  1      retries exhausted, PLL held in reset
//  lol_count    out  LOL_W  saturating count of lock losses while in RUN
//  state        out  3      current FSM state, for debug/status register
// BEHAVIOUR
//  Reset (async assert, any time): state=RESET, pll_rst=1, clk_ok=0, fault=0, restart_ack=0,
//   lol_count=0, retries=0, counters=0. A mid-sequence reset aborts the sequence and restarts it.
//  pll_locked passes through a 2-FF synchronizer -> locked_s (2-cycle latency). The FSM uses
//   only locked_s. All outputs are registered.
//  States:
//   RESET     pll_rst=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK. The counter is
//             cleared on every entry.
//   WAIT_LOCK pll_rst=0. When locked_s=1, go to STABLE. After LOCK_TIMEOUT cycles without
//             lock, retries++. If retries reaches MAX_RETRIES go to FAULT, otherwise go to RESET.
//   STABLE    Count cycles with locked_s=1.
//             - If locked_s=0: retries++ and go to RESET (or FAULT on exhaustion).
//             - When the count reaches STABLE_CYCLES: go to RUN, set clk_ok=1 and clear retries.
//   RUN       clk_ok=1.
//             - locked_s=0: clk_ok=0 and pll_rst=1 on the next edge, go to RESET, lol_count++
//               (saturates at all-ones, never wraps).
//   FAULT     pll_rst=1, fault=1, clk_ok=0. Stay here until a restart is accepted.
//  Restart handshake:
//   - Sampled only in RUN or FAULT, and only while armed.
//   - Acceptance: restart_ack=1 for 1 cycle, retries=0, fault=0, clk_ok=0, go to RESET.
//   - After an ack, restart_req must be seen low for >=1 cycle to re-arm.
//   - A request held during RESET/WAIT_LOCK/STABLE is served on RUN/FAULT entry.
//  Simultaneous events in RUN: lock loss and restart_req in the same cycle. Restart wins
//   (ack issued), and lol_count still increments.
//  Timeout and lock in the same cycle in WAIT_LOCK: lock wins, go to STABLE.
//  Counter width = $clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1). One shared counter.
//  state encoding: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
// STRUCTURE
//  pll_ctrl_pkg: state encoding localparams and the default timing constants, shared with the
//   status-register block that decodes the state port.
//  Sub-module: sync_2ff (generic 2-flop synchronizer, async active-low reset, reset value 0).
//  Remainder: one FSM plus the shared cycle counter, retry counter and lol counter in this file.
// TESTING (use small params: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
//  1. Release reset_n; raise pll_locked 3 cycles after pll_rst falls -> pll_rst high exactly
//     4 cycles; clk_ok rises 2+8+1 cycles after locked rises; state goes 0->1->2->3.
//  2. Hold pll_locked=0 -> two 20-cycle WAIT_LOCK windows separated by a 4-cycle reset pulse;
//     then state=4, fault=1, pll_rst=1. A restart_req pulse -> 1 ack, fault=0, new sequence.
//  3. In RUN, drop pll_locked 5 times -> clk_ok falls <=3 cycles after each drop; lol_count=5.
//     Force lol_count to 255 and drop once more -> stays 255.
//  4. Glitch pll_locked low for 1 cycle at STABLE count 6 -> RESET, retries=1; the next clean
//     lock reaches RUN, retries=0.
//  5. Hold restart_req high continuously through RUN -> exactly one ack. Lower it for 1 cycle,
//     raise it again after RUN is re-entered -> second ack.
//  6. Assert reset_n low in STABLE and in FAULT -> all outputs return to reset values
//     asynchronously; the sequence restarts from RESET.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// State encoding and default timing constants for the PLL lock supervisor; also used by the
// status-register block that decodes the supervisor's state port.
package pll_ctrl_pkg;

    localparam logic [2:0] S_RESET     = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    typedef enum logic [2:0] {
        ST_RESET     = S_RESET,
        ST_WAIT_LOCK = S_WAIT_LOCK,
        ST_STABLE    = S_STABLE,
        ST_RUN       = S_RUN,
        ST_FAULT     = S_FAULT
    } pll_state_e;

    // 50 MHz reference: LOCK_TIMEOUT is 1 ms.
    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 50000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 3;
    localparam int DEF_LOL_W         = 8;

    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for inputs asynchronous to clk_i; resets to zero.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the system PLL reset, qualifies its lock flag and publishes clk_ok / fault status.
//  state     | meaning
//  RESET     | PLL held in reset for RST_CYCLES
//  WAIT_LOCK | reset released, waiting up to LOCK_TIMEOUT for lock
//  STABLE    | lock seen, must stay high for STABLE_CYCLES
//  RUN       | clk_ok asserted, watching for loss of lock
//  FAULT     | retries exhausted, PLL held in reset until a restart
module pll_lock_supervisor
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int LOL_W         = DEF_LOL_W
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             pll_locked_i,
    output logic             pll_rst_o,
    input  logic             restart_req_i,
    output logic             restart_ack_o,
    output logic             clk_ok_o,
    output logic             fault_o,
    output logic [LOL_W-1:0] lol_count_o,
    output logic [2:0]       state_o
);

    localparam int CNT_W = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int RET_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RET_W-1:0] RETRY_LIMIT  = RET_W'(MAX_RETRIES);

    pll_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RET_W-1:0] retries_q, retries_d;
    logic [LOL_W-1:0] lol_q, lol_d;
    logic             armed_q, armed_d;
    logic             ack_q, ack_d;
    logic             pll_rst_q;
    logic             clk_ok_q;
    logic             fault_q;

    logic             locked_s;
    logic             restart_take;
    logic [RET_W-1:0] retry_inc;
    pll_state_e       fail_state;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk_i   (clk_i),
        .rst_n_i (reset_n_i),
        .d_i     (pll_locked_i),
        .q_o     (locked_s)
    );

    assign restart_take = armed_q & restart_req_i;
    assign retry_inc    = retries_q + 1'b1;
    assign fail_state   = (retry_inc >= RETRY_LIMIT) ? ST_FAULT : ST_RESET;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        lol_d     = lol_q;
        ack_d     = 1'b0;
        // Any cycle with the request low re-arms the handshake.
        armed_d   = armed_q | ~restart_req_i;

        case (state_q)
            ST_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is tested first so it wins over a coincident timeout.
                if (locked_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retries_d = retry_inc;
                    state_d   = fail_state;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    retries_d = retry_inc;
                    state_d   = fail_state;
                    cnt_d     = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    retries_d = '0;
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                    if (lol_q != {LOL_W{1'b1}}) lol_d = lol_q + 1'b1;
                end
                if (restart_take) begin
                    state_d   = ST_RESET;
                    cnt_d     = '0;
                    retries_d = '0;
                    ack_d     = 1'b1;
                    armed_d   = 1'b0;
                end
            end
            ST_FAULT: begin
                if (restart_take) begin
                    state_d   = ST_RESET;
                    cnt_d     = '0;
                    retries_d = '0;
                    ack_d     = 1'b1;
                    armed_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    // Status outputs are registered from the next state so they change with state_o.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            retries_q <= '0;
            lol_q     <= '0;
            armed_q   <= 1'b1;
            ack_q     <= 1'b0;
            pll_rst_q <= 1'b1;
            clk_ok_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            lol_q     <= lol_d;
            armed_q   <= armed_d;
            ack_q     <= ack_d;
            pll_rst_q <= (state_d == ST_RESET) || (state_d == ST_FAULT);
            clk_ok_q  <= (state_d == ST_RUN);
            fault_q   <= (state_d == ST_FAULT);
        end
    end

    assign pll_rst_o     = pll_rst_q;
    assign restart_ack_o = ack_q;
    assign clk_ok_o      = clk_ok_q;
    assign fault_o       = fault_q;
    assign lol_count_o   = lol_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with a cycle-level behavioural model checked every cycle.
module tb_pll_lock_supervisor;

    localparam int RST   = 4;
    localparam int TO    = 20;
    localparam int STAB  = 8;
    localparam int MAXR  = 2;
    localparam int LOLMX = 255;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       restart_req = 1'b0;
    logic       pll_rst_o;
    logic       restart_ack_o;
    logic       clk_ok_o;
    logic       fault_o;
    logic [7:0] lol_count_o;
    logic [2:0] state_o;

    int n_vec = 0;
    int n_err = 0;
    int n_ack = 0;

    pll_lock_supervisor #(
        .RST_CYCLES    (RST),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (STAB),
        .MAX_RETRIES   (MAXR),
        .LOL_W         (8)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .pll_locked_i  (pll_locked),
        .pll_rst_o     (pll_rst_o),
        .restart_req_i (restart_req),
        .restart_ack_o (restart_ack_o),
        .clk_ok_o      (clk_ok_o),
        .fault_o       (fault_o),
        .lol_count_o   (lol_count_o),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: phase numbers follow the published state codes; elapsed = edges spent in the phase.
    int m_phase = 0, m_elapsed = 0, m_fails = 0, m_lol = 0, m_next = 0;
    bit m_armed = 1'b1, m_ack = 1'b0, m_ls = 1'b0, m_take = 1'b0;
    bit [1:0] m_hist = 2'b00;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_phase = 0; m_elapsed = 0; m_fails = 0; m_lol = 0;
                m_armed = 1'b1; m_ack = 1'b0; m_hist = 2'b00;
            end else begin
                m_ls   = m_hist[1];
                m_hist = {m_hist[0], pll_locked};
                m_next = m_phase;
                m_take = 1'b0;
                m_ack  = 1'b0;
                case (m_phase)
                    0: if (m_elapsed + 1 == RST) m_next = 1;
                    1: begin
                        if (m_ls) m_next = 2;
                        else if (m_elapsed + 1 == TO) begin
                            m_fails++;
                            m_next = (m_fails >= MAXR) ? 4 : 0;
                        end
                    end
                    2: begin
                        if (!m_ls) begin
                            m_fails++;
                            m_next = (m_fails >= MAXR) ? 4 : 0;
                        end else if (m_elapsed + 1 == STAB) begin
                            m_next  = 3;
                            m_fails = 0;
                        end
                    end
                    3: begin
                        if (!m_ls) begin
                            m_next = 0;
                            if (m_lol < LOLMX) m_lol++;
                        end
                        m_take = m_armed && restart_req;
                    end
                    4: m_take = m_armed && restart_req;
                    default: m_next = 0;
                endcase
                if (!restart_req) m_armed = 1'b1;
                if (m_take) begin
                    m_ack = 1'b1; m_fails = 0; m_next = 0; m_armed = 1'b0;
                end
                m_elapsed = (m_next == m_phase) ? m_elapsed + 1 : 0;
                m_phase   = m_next;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("mdl_state",   int'(state_o),       m_phase);
            check("mdl_pll_rst", int'(pll_rst_o),     (m_phase == 0 || m_phase == 4) ? 1 : 0);
            check("mdl_clk_ok",  int'(clk_ok_o),      (m_phase == 3) ? 1 : 0);
            check("mdl_fault",   int'(fault_o),       (m_phase == 4) ? 1 : 0);
            check("mdl_ack",     int'(restart_ack_o), int'(m_ack));
            check("mdl_lol",     int'(lol_count_o),   m_lol);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (restart_ack_o) n_ack++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_state(input int s, input int budget, input string tag);
        int n;
        n = 0;
        while (int'(state_o) != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(state_o), s);
    endtask

    task automatic dwell_state(input int s, output int n);
        n = 0;
        while (int'(state_o) == s && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic drop_lock(output int n);
        @(negedge clk);
        pll_locked = 1'b0;
        n = 0;
        while (clk_ok_o && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        pll_locked = 1'b1;
    endtask

    task automatic glitch_in_stable(input string tag);
        wait_state(2, 60, {tag, "_stable"});
        repeat (4) @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        wait_state(0, 10, {tag, "_reset"});
        check({tag, "_no_fault"}, int'(fault_o), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},   int'(state_o),       0);
        check({tag, "_pll_rst"}, int'(pll_rst_o),     1);
        check({tag, "_clk_ok"},  int'(clk_ok_o),      0);
        check({tag, "_fault"},   int'(fault_o),       0);
        check({tag, "_ack"},     int'(restart_ack_o), 0);
        check({tag, "_lol"},     int'(lol_count_o),   0);
    endtask

    initial begin
        int n;
        int a0;
        bit saw_stable;

        #23;
        check_reset_values("por");

        // 1: power-up sequence
        @(negedge clk);
        #2 reset_n = 1'b1;
        n = 0;
        while (pll_rst_o && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t1_rst_width", n, 4);
        check("t1_wait_lock", int'(state_o), 1);
        repeat (3) @(negedge clk);
        pll_locked = 1'b1;
        n = 0;
        saw_stable = 1'b0;
        while (!clk_ok_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (state_o == 3'd2) saw_stable = 1'b1;
        end
        check("t1_clk_ok_delay", n, 11);
        check("t1_saw_stable", int'(saw_stable), 1);
        check("t1_run", int'(state_o), 3);

        // 3: losses of lock in RUN, then saturation
        for (int i = 0; i < 5; i++) begin
            drop_lock(n);
            check("t3_clk_ok_fall", n, 3);
            wait_state(3, 100, "t3_relock");
        end
        check("t3_lol_5", int'(lol_count_o), 5);
        for (int i = 5; i < 255; i++) begin
            drop_lock(n);
            wait_state(3, 100, "t3_relock_sat");
        end
        check("t3_lol_255", int'(lol_count_o), 255);
        drop_lock(n);
        wait_state(3, 100, "t3_relock_last");
        check("t3_lol_stays_255", int'(lol_count_o), 255);

        // 5: restart held high -> single ack; re-arm -> second ack
        a0 = n_ack;
        @(negedge clk);
        restart_req = 1'b1;
        repeat (40) @(negedge clk);
        check("t5_back_in_run", int'(state_o), 3);
        check("t5_one_ack", n_ack - a0, 1);
        restart_req = 1'b0;
        @(negedge clk);
        restart_req = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_two_acks", n_ack - a0, 2);
        restart_req = 1'b0;
        wait_state(3, 100, "t5_run_again");

        // 4: glitch in STABLE, then retries must be cleared by RUN entry
        drop_lock(n);
        glitch_in_stable("t4a");
        wait_state(3, 100, "t4a_run");
        drop_lock(n);
        glitch_in_stable("t4b");
        wait_state(3, 100, "t4b_run");

        // 2: no lock -> two timeouts -> FAULT, then restart
        @(negedge clk);
        pll_locked = 1'b0;
        wait_state(1, 50, "t2_wait1");
        dwell_state(1, n);
        check("t2_window1", n, 20);
        dwell_state(0, n);
        check("t2_reset_pulse", n, 4);
        dwell_state(1, n);
        check("t2_window2", n, 20);
        check("t2_fault_state", int'(state_o), 4);
        check("t2_fault", int'(fault_o), 1);
        check("t2_pll_rst", int'(pll_rst_o), 1);
        a0 = n_ack;
        @(negedge clk);
        restart_req = 1'b1;
        @(negedge clk);
        restart_req = 1'b0;
        check("t2_ack", int'(restart_ack_o), 1);
        check("t2_fault_clr", int'(fault_o), 0);
        check("t2_restart_state", int'(state_o), 0);
        pll_locked = 1'b1;
        wait_state(3, 100, "t2_run");
        check("t2_ack_count", n_ack - a0, 1);

        // 6: async reset in STABLE and in FAULT
        drop_lock(n);
        wait_state(2, 60, "t6_stable");
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_values("t6_rst_stable");
        @(negedge clk);
        #2 reset_n = 1'b1;
        wait_state(3, 100, "t6_run");
        @(negedge clk);
        pll_locked = 1'b0;
        wait_state(4, 200, "t6_fault");
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_values("t6_rst_fault");
        @(negedge clk);
        #2 reset_n = 1'b1;

        // timeout and lock on the same edge: lock wins
        wait_state(1, 20, "tl_wait");
        repeat (17) @(negedge clk);
        pll_locked = 1'b1;
        repeat (3) @(negedge clk);
        check("tl_lock_wins", int'(state_o), 2);
        wait_state(3, 100, "tl_run");

        // lock loss and restart on the same edge in RUN
        a0 = n_ack;
        @(negedge clk);
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        restart_req = 1'b1;
        @(negedge clk);
        restart_req = 1'b0;
        pll_locked  = 1'b1;
        check("sim_ack", int'(restart_ack_o), 1);
        check("sim_lol", int'(lol_count_o), 1);
        check("sim_state", int'(state_o), 0);
        check("sim_clk_ok", int'(clk_ok_o), 0);
        wait_state(3, 100, "sim_run");
        check("sim_ack_count", n_ack - a0, 1);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
